// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic sensor scheduler.
package sonic_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_GAP
   } state_t;

   localparam logic [19:0] DIST_TIMEOUT = 20'hFFFFF;
   localparam int          CM_NUM       = 17;
   localparam int          CM_DEN       = 1000;

   // Echo high-width in us to distance in cm, evaluated at 25 bits.
   function automatic logic [19:0] width_to_cm(input logic [24:0] width);
      logic [24:0] prod;
      prod = width * 25'(CM_NUM);
      return 20'(prod / 25'(CM_DEN));
   endfunction

endpackage

// File: rtl/sonic_echo_sync.sv
// Per-bit 2-FF synchronizer plus delay FF, producing single-cycle rise/fall strobes.
module sonic_echo_sync #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] echo,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall
);

   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic [W-1:0] s3;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= echo;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

endmodule

// File: rtl/sonic_scheduler.sv
// Round-robin trigger/echo-timing controller for N ultrasonic sensors.
// Build option SONIC_SCHED_MASK_EN adds a sensor_mask input selecting which sensors are polled.
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | stopped, waiting for enable (and a non-empty mask)
// S_TRIG      | trigger pulse high on the selected sensor
// S_WAIT_RISE | waiting for the echo rising edge, bounded by TIMEOUT_US
// S_MEASURE   | timing echo high-width in ticks, bounded by TIMEOUT_US
// S_GAP       | result issued, waiting out the remainder of the slot
module sonic_scheduler
   import sonic_pkg::*;
#(
   parameter int N_SENSORS  = 3,
   parameter int CLK_DIV    = 100,
   parameter int TRIG_US    = 10,
   parameter int TIMEOUT_US = 30000,
   parameter int SLOT_US    = 60000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [N_SENSORS-1:0] echo,
`ifdef SONIC_SCHED_MASK_EN
   input  logic [N_SENSORS-1:0] sensor_mask,
`endif
   output logic [N_SENSORS-1:0] trig,
   output logic                 dist_valid,
   output logic [2:0]           dist_id,
   output logic [19:0]          dist_cm,
   output logic                 dist_timeout,
   output logic                 busy
);

   localparam int PW = $clog2(CLK_DIV + 1);
   localparam int TW = $clog2(TIMEOUT_US + 1);
   localparam int SW = $clog2(SLOT_US + TRIG_US + 2 * TIMEOUT_US + 2);

   state_t                 state;
   logic [2:0]             idx;
   logic [PW-1:0]          presc;
   logic [SW-1:0]          slot_cnt;
   logic [TW-1:0]          timer;
   logic [TW-1:0]          width;
   logic [N_SENSORS-1:0]   rise;
   logic [N_SENSORS-1:0]   fall;
   logic [N_SENSORS-1:0]   poll_mask;
   logic                   tick;
   logic                   rise_sel;
   logic                   fall_sel;
   logic                   gap_done;
   logic                   run_ok;
   logic [2:0]             nxt_base;
   logic [2:0]             first_idx;
   logic [2:0]             next_idx;

`ifdef SONIC_SCHED_MASK_EN
   assign poll_mask = sensor_mask;
`else
   assign poll_mask = '1;
`endif

   function automatic logic [N_SENSORS-1:0] onehot(input logic [2:0] i);
      logic [N_SENSORS-1:0] oh;
      for (int k = 0; k < N_SENSORS; k++) oh[k] = (i == 3'(k));
      return oh;
   endfunction

   // First polled sensor at or after start, wrapping; start itself if none is polled.
   function automatic logic [2:0] pick(input logic [2:0] start, input logic [N_SENSORS-1:0] m);
      logic [2:0] r;
      int         c;
      r = start;
      for (int k = N_SENSORS - 1; k >= 0; k--) begin
         c = (int'(start) + k) % N_SENSORS;
         if (m[c]) r = 3'(c);
      end
      return r;
   endfunction

   sonic_echo_sync #(.W(N_SENSORS)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .echo (echo),
      .rise (rise),
      .fall (fall)
   );

   assign tick      = (presc == PW'(CLK_DIV - 1));
   assign rise_sel  = |(rise & onehot(idx));
   assign fall_sel  = |(fall & onehot(idx));
   assign run_ok    = enable && (|poll_mask);
   assign nxt_base  = (idx == 3'(N_SENSORS - 1)) ? 3'd0 : idx + 3'd1;
   assign first_idx = pick(idx, poll_mask);
   assign next_idx  = pick(nxt_base, poll_mask);
   // A long wait plus a long measurement can overrun the slot; end the gap at once then.
   assign gap_done  = (slot_cnt >= SW'(SLOT_US)) || (tick && (slot_cnt == SW'(SLOT_US - 1)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         presc        <= '0;
         slot_cnt     <= '0;
         timer        <= '0;
         width        <= '0;
         trig         <= '0;
         dist_valid   <= 1'b0;
         dist_id      <= '0;
         dist_cm      <= '0;
         dist_timeout <= 1'b0;
         busy         <= 1'b0;
      end else begin
         dist_valid <= 1'b0;
         presc      <= tick ? '0 : presc + PW'(1);
         if (state != S_IDLE && tick) slot_cnt <= slot_cnt + SW'(1);

         case (state)
            S_IDLE: begin
               if (run_ok) begin
                  idx      <= first_idx;
                  trig     <= onehot(first_idx);
                  presc    <= '0;
                  slot_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= S_TRIG;
               end
            end

            S_TRIG: begin
               if (tick && (slot_cnt == SW'(TRIG_US - 1))) begin
                  trig  <= '0;
                  timer <= TW'(TIMEOUT_US);
                  state <= S_WAIT_RISE;
               end
            end

            S_WAIT_RISE: begin
               if (rise_sel) begin
                  width <= '0;
                  state <= S_MEASURE;
               end else if (tick) begin
                  if (timer == TW'(1)) begin
                     dist_valid   <= 1'b1;
                     dist_id      <= idx;
                     dist_cm      <= DIST_TIMEOUT;
                     dist_timeout <= 1'b1;
                     state        <= S_GAP;
                  end else begin
                     timer <= timer - TW'(1);
                  end
               end
            end

            S_MEASURE: begin
               if (fall_sel) begin
                  dist_valid   <= 1'b1;
                  dist_id      <= idx;
                  dist_cm      <= width_to_cm(25'(width));
                  dist_timeout <= 1'b0;
                  state        <= S_GAP;
               end else if (tick) begin
                  if (width == TW'(TIMEOUT_US - 1)) begin
                     dist_valid   <= 1'b1;
                     dist_id      <= idx;
                     dist_cm      <= DIST_TIMEOUT;
                     dist_timeout <= 1'b1;
                     state        <= S_GAP;
                  end else begin
                     width <= width + TW'(1);
                  end
               end
            end

            S_GAP: begin
               if (gap_done) begin
                  idx <= next_idx;
                  if (run_ok) begin
                     trig     <= onehot(next_idx);
                     presc    <= '0;
                     slot_cnt <= '0;
                     state    <= S_TRIG;
                  end else begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end
            end

            default: begin
               trig  <= '0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sonic_scheduler.sv
// Scoreboard bench for sonic_scheduler: directed echo stimulus pushes expected results, a monitor checks them.
module tb_sonic_scheduler;

   localparam int N_SENSORS  = 3;
   localparam int CLK_DIV    = 2;
   localparam int TRIG_US    = 10;
   localparam int TIMEOUT_US = 1100;
   localparam int SLOT_US    = 2400;
   localparam int SLOT_CYC   = SLOT_US * CLK_DIV;
   localparam int TO_CYC     = (TRIG_US + TIMEOUT_US) * CLK_DIV;

   typedef struct {
      int id;
      int cm;
      int to;
      int cyc;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 enable;
   logic [N_SENSORS-1:0] echo;
   logic [N_SENSORS-1:0] trig;
   logic                 dist_valid;
   logic [2:0]           dist_id;
   logic [19:0]          dist_cm;
   logic                 dist_timeout;
   logic                 busy;
`ifdef SONIC_SCHED_MASK_EN
   logic [N_SENSORS-1:0] sensor_mask = 3'b111;
`endif

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_start = 0;

   sonic_scheduler #(
      .N_SENSORS  (N_SENSORS),
      .CLK_DIV    (CLK_DIV),
      .TRIG_US    (TRIG_US),
      .TIMEOUT_US (TIMEOUT_US),
      .SLOT_US    (SLOT_US)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .echo         (echo),
`ifdef SONIC_SCHED_MASK_EN
      .sensor_mask  (sensor_mask),
`endif
      .trig         (trig),
      .dist_valid   (dist_valid),
      .dist_id      (dist_id),
      .dist_cm      (dist_cm),
      .dist_timeout (dist_timeout),
      .busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every result strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && dist_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got id %0d cm %0d timeout %0d, expected none", dist_id, dist_cm, dist_timeout);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("result_id", dist_id, e.id);
            check("result_cm", dist_cm, e.cm);
            check("result_timeout", dist_timeout, e.to);
            if (e.cyc >= 0) check("result_cycle", cyc, e.cyc);
         end
      end
   end

   task automatic wait_trig_start(input int id, input bit chk_period);
      int n = 0;
      while (trig == 0 && n < 12000) begin
         @(negedge clk);
         n++;
      end
      check("trig_onehot", trig, 1 << id);
      if (chk_period) check("slot_period", cyc - last_start, SLOT_CYC);
      last_start = cyc;
   endtask

   task automatic wait_trig_end();
      int n = 0;
      while (trig != 0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("trig_width", cyc - last_start, TRIG_US * CLK_DIV);
   endtask

   task automatic echo_pulse(input int id, input int dly, input int us, input int cm);
      repeat (dly) @(negedge clk);
      echo[id] = 1'b1;
      repeat (us * CLK_DIV) @(negedge clk);
      echo[id] = 1'b0;
      q.push_back('{id, cm, 0, cyc + 3});
   endtask

   task automatic push_timeout(input int id);
      q.push_back('{id, 20'hFFFFF, 1, last_start + TO_CYC});
   endtask

   task automatic wait_idle(input int req_cyc);
      int n = 0;
      while (busy && n < 12000) begin
         @(negedge clk);
         n++;
      end
      check("busy_drop_cycle", cyc, req_cyc);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded time limit, %0d errors so far", errors);
      $fatal(1);
   end

   initial begin
      rst    = 1'b1;
      enable = 1'b0;
      echo   = '0;
      repeat (3) @(negedge clk);
      check("reset_trig", trig, 0);
      check("reset_busy", busy, 0);
      check("reset_valid", dist_valid, 0);
      check("reset_cm", dist_cm, 0);
      check("reset_timeout", dist_timeout, 0);
      rst = 1'b0;
      @(negedge clk);
      enable = 1'b1;

      // Normal measurements across all three sensors
      wait_trig_start(0, 1'b0);
      wait_trig_end();
      echo_pulse(0, 10, 1010, 17);
      wait_trig_start(1, 1'b1);
      wait_trig_end();
      echo_pulse(1, 10, 590, 10);
      wait_trig_start(2, 1'b1);
      wait_trig_end();
      echo_pulse(2, 10, 1070, 18);

      // Echo 0 stuck high before its trigger; glitch on unselected echo 2
      repeat (100) @(negedge clk);
      echo[0] = 1'b1;
      wait_trig_start(0, 1'b1);
      wait_trig_end();
      push_timeout(0);
      repeat (50) @(negedge clk);
      echo[2] = 1'b1;
      repeat (6) @(negedge clk);
      echo[2] = 1'b0;
      repeat (2400) @(negedge clk);
      echo[0] = 1'b0;

      // Missing echo on sensor 1
      wait_trig_start(1, 1'b1);
      wait_trig_end();
      push_timeout(1);

      // Enable dropped during a measurement on sensor 2
      wait_trig_start(2, 1'b1);
      wait_trig_end();
      repeat (10) @(negedge clk);
      echo[2] = 1'b1;
      repeat (100) @(negedge clk);
      enable = 1'b0;
      repeat (500) @(negedge clk);
      echo[2] = 1'b0;
      q.push_back('{2, 5, 0, cyc + 3});
      wait_idle(last_start + SLOT_CYC);
      repeat (200) @(negedge clk);
      check("stopped_trig", trig, 0);
      check("stopped_busy", busy, 0);

      // Resume at retained index, then reset mid-trigger
      enable = 1'b1;
      wait_trig_start(0, 1'b0);
      repeat (5) @(negedge clk);
      rst    = 1'b1;
      enable = 1'b0;
      @(negedge clk);
      check("rst_mid_trig_trig", trig, 0);
      check("rst_mid_trig_busy", busy, 0);
      check("rst_mid_trig_cm", dist_cm, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      enable = 1'b1;
      wait_trig_start(0, 1'b0);
      wait_trig_end();
      enable = 1'b0;
      push_timeout(0);
      wait_idle(last_start + SLOT_CYC);

`ifdef SONIC_SCHED_MASK_EN
      sensor_mask = 3'b101;
      enable      = 1'b1;
      wait_trig_start(2, 1'b0);
      wait_trig_end();
      push_timeout(2);
      wait_trig_start(0, 1'b1);
      wait_trig_end();
      push_timeout(0);
      sensor_mask = 3'b000;
      wait_idle(last_start + SLOT_CYC);
      repeat (100) @(negedge clk);
      check("mask_zero_busy", busy, 0);
      check("mask_zero_trig", trig, 0);
      sensor_mask = 3'b010;
      wait_trig_start(1, 1'b0);
      wait_trig_end();
      enable = 1'b0;
      push_timeout(1);
      wait_idle(last_start + SLOT_CYC);
`endif

      repeat (10) @(negedge clk);
      check("scoreboard_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
